// File: rtl/ldpc_minsum_decoder.sv
`timescale 1ns/1ps
// ldpc_minsum_decoder
// Fully parallel flooding min-sum LDPC decoder. The parity-check matrix is a
// parameter. Each iteration spends one cycle on check nodes (CN) and one on
// variable nodes (VN). Every iteration is preceded by a syndrome check (CHK),
// which ends the frame early on a zero syndrome or when the iteration limit
// is reached.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   start       frame start, sampled only in IDLE
//   llr_in      N channel LLRs, variable n at [n*WIDTH +: WIDTH], >0 means bit 0
//   max_iter    iteration limit, sampled together with start
//   busy        high in every state except IDLE
//   done        one-cycle pulse while the result is valid
//   success     final syndrome was zero
//   codeword    hard decision, bit n is variable n
//   iter_count  number of completed iterations
module ldpc_minsum_decoder #(
  parameter int WIDTH = 8,
  parameter int N     = 6,
  parameter int M     = 3,
  parameter logic [M*N-1:0] H = 18'b100101_010110_001011,
  parameter int ITW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*WIDTH-1:0] llr_in,
  input  logic [ITW-1:0]   max_iter,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic [N-1:0]     codeword,
  output logic [ITW-1:0]   iter_count
);

  localparam int SW = WIDTH + $clog2(M + 1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXS = $signed({{(SW-WIDTH){1'b0}}, MAXV});
  localparam logic signed [SW-1:0] MINS = -MAXS;

  typedef enum logic [2:0] {S_IDLE, S_CHK, S_CN, S_VN, S_DONE} state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_llr [N];
  logic [WIDTH-1:0] r_v2c [M][N];
  logic [WIDTH-1:0] r_c2v [M][N];
  logic [N-1:0]     r_cw;
  logic             r_succ;
  logic [ITW-1:0]   r_iter;
  logic [ITW-1:0]   r_limit;

  logic [WIDTH-1:0] w_c2v [M][N];
  logic [WIDTH-1:0] w_v2c [M][N];
  logic [WIDTH-1:0] w_p   [N];
  logic signed [SW-1:0] w_psum [N];
  logic [M-1:0]     w_synd;
  logic             w_sgn;
  logic             w_any;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_min;

  function automatic logic signed [SW-1:0] sx(input logic [WIDTH-1:0] x);
    return $signed({{(SW-WIDTH){x[WIDTH-1]}}, x});
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    if (x > MAXS)      return MAXV;
    else if (x < MINS) return ~MAXV + 1'b1;
    else               return x[WIDTH-1:0];
  endfunction

  // Syndrome over the current hard decision.
  always_comb begin
    w_synd = '0;
    for (int unsigned m = 0; m < M; m++)
      w_synd[m] = ^(r_cw & H[m*N +: N]);
  end

  // Check nodes: extrinsic sign product and minimum magnitude per edge.
  // A row with no other edge leaves the output at 0.
  always_comb begin
    w_sgn = 1'b0;
    w_any = 1'b0;
    w_mag = '0;
    w_min = '0;
    for (int unsigned m = 0; m < M; m++) begin
      for (int unsigned n = 0; n < N; n++) begin
        w_c2v[m][n] = '0;
        w_sgn = 1'b0;
        w_any = 1'b0;
        w_min = MAXV;
        if (H[m*N+n]) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (H[m*N+k] && k != n) begin
              w_sgn = w_sgn ^ r_v2c[m][k][WIDTH-1];
              if (r_v2c[m][k] == MINNEG)      w_mag = MAXV;
              else if (r_v2c[m][k][WIDTH-1]) w_mag = ~r_v2c[m][k] + 1'b1;
              else                           w_mag = r_v2c[m][k];
              if (w_mag < w_min) w_min = w_mag;
              w_any = 1'b1;
            end
          end
          if (w_any) w_c2v[m][n] = w_sgn ? (~w_min + 1'b1) : w_min;
        end
      end
    end
  end

  // Variable nodes: clamped posterior, then extrinsic v2c from the clamped posterior.
  always_comb begin
    for (int unsigned n = 0; n < N; n++) begin
      w_psum[n] = sx(r_llr[n]);
      for (int unsigned m = 0; m < M; m++)
        if (H[m*N+n]) w_psum[n] = w_psum[n] + sx(r_c2v[m][n]);
      w_p[n] = sat(w_psum[n]);
    end
    for (int unsigned m = 0; m < M; m++)
      for (int unsigned n = 0; n < N; n++)
        w_v2c[m][n] = H[m*N+n] ? sat(sx(w_p[n]) - sx(r_c2v[m][n])) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CHK;
      S_CHK: begin
        if (w_synd == '0)          w_next = S_DONE;
        else if (r_iter == r_limit) w_next = S_DONE;
        else                       w_next = S_CN;
      end
      S_CN:   w_next = S_VN;
      S_VN:   w_next = S_CHK;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < N; n++) r_llr[n] <= '0;
      for (int unsigned m = 0; m < M; m++)
        for (int unsigned n = 0; n < N; n++) begin
          r_v2c[m][n] <= '0;
          r_c2v[m][n] <= '0;
        end
      r_cw    <= '0;
      r_succ  <= 1'b0;
      r_iter  <= '0;
      r_limit <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          for (int unsigned n = 0; n < N; n++) begin
            r_llr[n] <= llr_in[n*WIDTH +: WIDTH];
            r_cw[n]  <= llr_in[n*WIDTH + WIDTH - 1];
          end
          for (int unsigned m = 0; m < M; m++)
            for (int unsigned n = 0; n < N; n++)
              r_v2c[m][n] <= H[m*N+n] ? llr_in[n*WIDTH +: WIDTH] : '0;
          r_limit <= max_iter;
          r_iter  <= '0;
          r_succ  <= 1'b0;
        end
        S_CHK: begin
          if (w_synd == '0)           r_succ <= 1'b1;
          else if (r_iter == r_limit) r_succ <= 1'b0;
        end
        S_CN: begin
          for (int unsigned m = 0; m < M; m++)
            for (int unsigned n = 0; n < N; n++) r_c2v[m][n] <= w_c2v[m][n];
        end
        S_VN: begin
          for (int unsigned m = 0; m < M; m++)
            for (int unsigned n = 0; n < N; n++) r_v2c[m][n] <= w_v2c[m][n];
          for (int unsigned n = 0; n < N; n++) r_cw[n] <= w_p[n][WIDTH-1];
          r_iter <= r_iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign success    = r_succ;
  assign codeword   = r_cw;
  assign iter_count = r_iter;

endmodule

// File: doc/ldpc_minsum_decoder.md
# ldpc_minsum_decoder

Parametrised, fully parallel flooding min-sum LDPC decoder. It replaces the fixed 6x3 decoder with a clocked state machine driven by a start/done handshake, and takes the parity-check matrix as a parameter. Each iteration uses registered check-to-variable and variable-to-check messages. It terminates early on a zero syndrome or when `max_iter` iterations are reached, and reports codeword, success and iteration count to the frame controller.

## Interface
- `WIDTH`, 8: signed two's-complement LLR/message width.
- `N`, 6: codeword length (variable nodes).
- `M`, 3: parity checks (check nodes).
- `H`, `18'b100101_010110_001011`: parity-check matrix, M*N bits; bit `H[m*N+n]`=1 means edge check m – variable n. Default rows: row0 = {n0,n1,n3}, row1 = {n1,n2,n4}, row2 = {n0,n2,n5}.
- `ITW`, 8: width of the iteration limit and counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  frame start; sampled only in IDLE.
- `llr_in`  in  N*WIDTH  channel LLRs; variable n is `[n*WIDTH +: WIDTH]`; positive means bit 0.
- `max_iter`  in  ITW  iteration limit, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `success`  out  1  1 when the final syndrome is zero.
- `codeword`  out  N  hard decision; bit n is variable n.
- `iter_count`  out  ITW  number of completed iterations.

## Operation
- States: IDLE, CHK, CN, VN, DONE.
- IDLE → CHK on `start`. On this transition the block:
  - latches `llr_in` into the channel registers and `max_iter` into the limit register;
  - sets v2c[m][n] = llr[n] on edges and 0 elsewhere;
  - sets `codeword[n]` = sign bit of llr[n];
  - clears `iter_count` and `success`.
- CHK: computes the syndrome s[m] = XOR over the row-m edges of `codeword`.
  - All s = 0: set `success`=1 and go to DONE.
  - Otherwise, if `iter_count` == limit: set `success`=0 and go to DONE.
  - Otherwise go to CN.
- CN: for each edge, c2v[m][n] = (product of the signs of the other row-m v2c values) × (min of the other |v2c|).
  - Zero counts as positive.
  - |−2^(W−1)| saturates to 2^(W−1)−1.
  - A row with degree below 2 outputs 0.
- VN: all of the following are registered together in the VN cycle, and the block then goes to CHK.
  - Posterior p[n] = llr[n] + Σ c2v[·][n], summed at full width (WIDTH + clog2(M+1)) and clamped to ±(2^(W−1)−1).
  - v2c[m][n] = p[n] − c2v[m][n], clamped the same way.
  - `codeword[n]` = (p[n] < 0).
  - `iter_count`++.
- DONE: `done` is high for exactly this cycle; the next state is IDLE.
- `start` is ignored while `busy`.
- `codeword`, `success` and `iter_count` hold their values until the next accepted `start`.
- `max_iter` = 0 gives a channel-decision syndrome check only.

## Timing
- Reset values: all state and message registers 0; state IDLE; `busy`=0, `done`=0, `success`=0, `codeword`=0, `iter_count`=0.
- Asserting `rst` mid-frame aborts immediately; no `done` is produced.
- Latency: with `start` sampled at edge k, `done` is high during cycle k+2+3·I, where I is the final `iter_count`.
- `busy` rises in the cycle after the `start` edge and falls in the cycle after DONE.
- A new `start` is accepted in the first IDLE cycle after DONE. Back-to-back frames therefore have a gap of at least one cycle.

## Test plan
- Clean frame: all LLR = +20, `max_iter`=5 → `done` at start+2, `codeword`=000000, `success`=1, `iter_count`=0.
- Single error: LLR = +10 except n0 = −3, `max_iter`=5 → after iteration 1, p0 = 17 and p1 = 17. Expected `codeword`=0, `success`=1, `iter_count`=1, `done` at start+5.
- Iteration cap: same LLRs as the single-error case with `max_iter`=0 → `codeword` bit0 = 1, `success`=0, `iter_count`=0, `done` at start+2.
- Saturation: all LLR = −128, `max_iter`=3.
  - All magnitudes used are ≤127; no wrap is allowed.
  - Final `iter_count`=3 and `success`=0.
  - The `codeword` must match the golden model.
- Handshake: `start` pulsed again while `busy` → ignored; only one `done` pulse is produced.
- Reset abort: `rst` asserted during CN of iteration 1 → all outputs are 0 within the same cycle. A subsequent clean frame must then decode normally.
